passcode_fsm: RTL and testbench
===============================

Name: passcode_fsm

Overview:
- Consumes the one-cycle `confirm` / `long_confirm` pulses from the star-key stage, plus digit pulses from the numeric keypad stage.
- Buffers the entered digits and compares them against the stored passcode.
- Drives the door-open window, error pulses, the fail counter and the lockout.
- Supports changing the passcode while the door is open.

Parameters:
- MAX_DIGITS, 8: buffer depth in 4-bit digits (legal 4..8).
- MIN_DIGITS, 4: minimum length accepted for a new passcode.
- DEFAULT_CODE, 32'h0000_1234: passcode after reset, right-aligned, one digit per nibble.
- DEFAULT_LEN, 4: digit count of DEFAULT_CODE.
- MAX_FAIL, 3: consecutive failures that trigger lockout (1..3).
- OPEN_CYCLES, 50: length of the door-open window in clk cycles.
- LOCKOUT_CYCLES, 300: length of the lockout in clk cycles.
- TIMEOUT_CYCLES, 200: partial-entry timeout, used only with ENTRY_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- num_valid  in  1  one-cycle pulse; a digit key was pressed.
- num_digit  in  4  digit value 0..9, valid while num_valid=1; 10..15 ignored.
- confirm  in  1  one-cycle pulse; short star press.
- long_confirm  in  1  one-cycle pulse; long star press.
- door_open  out  1  high during the open window.
- err_pulse  out  1  one-cycle pulse on a rejected code.
- saved_pulse  out  1  one-cycle pulse when a new passcode is stored.
- locked_out  out  1  high during lockout.
- set_mode  out  1  high while a new passcode is being entered.
- digit_count  out  4  number of digits buffered, 0..MAX_DIGITS.
- fail_count  out  2  consecutive failures.

Behaviour:
- Reset (rst_n=0, async):
  - State=IDLE; buffer, digit_count, fail_count and all timers cleared.
  - door_open, err_pulse, saved_pulse, locked_out and set_mode all 0.
  - Stored code=DEFAULT_CODE, stored length=DEFAULT_LEN.
  - Reset mid-operation aborts any window, lockout or set sequence.
- States: IDLE, OPEN, SET, LOCKOUT. All outputs are registered.
- Digit capture (IDLE and SET only):
  - A num_valid pulse with num_digit<=9 shifts the digit into the low nibble of the buffer; digit_count increments.
  - At digit_count=MAX_DIGITS, further digits are dropped and a sticky overflow flag is set; digit_count saturates.
  - Digits in OPEN or LOCKOUT are ignored.
- Simultaneous events:
  - confirm or long_confirm in the same cycle as num_valid: the digit is dropped and the pulse is processed.
  - confirm and long_confirm together: long_confirm wins.
- IDLE + confirm: compare on that edge; results are visible the next cycle (latency 1).
  - Match requires no overflow, digit_count == stored length, and the low 4*len bits equal.
  - Match: state→OPEN, door_open=1, fail_count=0.
  - Mismatch: err_pulse=1 for one cycle and fail_count increments.
  - If fail_count reaches MAX_FAIL: state→LOCKOUT, locked_out=1.
  - In every case the buffer, digit_count and overflow are cleared.
  - confirm with digit_count=0 counts as a mismatch.
- IDLE + long_confirm: clears the buffer (cancel entry); no other effect.
- OPEN:
  - door_open stays high for exactly OPEN_CYCLES cycles, then state→IDLE.
  - long_confirm during OPEN: state→SET, door_open=0, set_mode=1, buffer cleared.
  - confirm during OPEN is ignored.
- SET:
  - confirm with MIN_DIGITS <= digit_count <= MAX_DIGITS and no overflow: the buffer and length are stored, saved_pulse=1, state→IDLE.
  - confirm otherwise: err_pulse=1, buffer cleared, stay in SET; fail_count is not changed.
  - long_confirm: abort to IDLE; the stored code is unchanged.
- LOCKOUT:
  - All inputs ignored for LOCKOUT_CYCLES cycles.
  - Then state→IDLE, locked_out=0, fail_count=0.
- Timers: separate down-counters sized for their parameters; no wrap-around, they stop at 0.

Optional Feature:
- Macro: ENTRY_TIMEOUT_EN.
- Defined:
  - In IDLE or SET with digit_count>0, an inactivity counter reloads to TIMEOUT_CYCLES on every accepted digit.
  - If it reaches 0, the buffer and overflow are cleared.
  - In SET, the timeout also returns the state to IDLE.
  - No err_pulse is generated.
- Undefined: partial entries persist indefinitely; the counter logic is absent.

Test Plan:
- Reset, enter 1,2,3,4, confirm → door_open=1 the next cycle for 50 cycles; fail_count=0.
- Enter 1,2,3,5, confirm, three times → err_pulse each time; fail_count 1,2 then locked_out=1 for 300 cycles; digits during lockout leave digit_count=0; afterwards 1234 opens.
- Enter 9 digits 1..9, confirm → overflow; err_pulse=1; digit_count reads 8 before confirm and 0 after.
- Open with 1234, long_confirm, enter 5,6,7,8,9, confirm → saved_pulse=1; 1234 now rejected; 56789 opens.
- In SET, enter 1,2,3, confirm → err_pulse, set_mode stays 1; then long_confirm → IDLE; 1234 still opens.
- num_valid(digit 4) coincident with confirm after 1,2,3 → digit dropped; mismatch err_pulse. With ENTRY_TIMEOUT_EN: enter 1,2, idle 200 cycles → digit_count=0.

Source files
------------

// File: rtl/passcode_fsm.sv
// passcode_fsm: keypad passcode checker with door-open window, fail lockout and passcode change
// ports: clk, rst_n (async active-low); num_valid/num_digit digit pulses; confirm/long_confirm star pulses;
//        door_open, err_pulse, saved_pulse, locked_out, set_mode, digit_count, fail_count (all registered)
// optional: define ENTRY_TIMEOUT_EN to drop partial entries after TIMEOUT_CYCLES without a digit
module passcode_fsm #(
  parameter int          MAX_DIGITS     = 8,
  parameter int          MIN_DIGITS     = 4,
  parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
  parameter int          DEFAULT_LEN    = 4,
  parameter int          MAX_FAIL       = 3,
  parameter int          OPEN_CYCLES    = 50,
  parameter int          LOCKOUT_CYCLES = 300,
  parameter int          TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       num_valid,
  input  logic [3:0] num_digit,
  input  logic       confirm,
  input  logic       long_confirm,
  output logic       door_open,
  output logic       err_pulse,
  output logic       saved_pulse,
  output logic       locked_out,
  output logic       set_mode,
  output logic [3:0] digit_count,
  output logic [1:0] fail_count
);
  localparam int W  = 4 * MAX_DIGITS;
  localparam int OW = $clog2(OPEN_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, OPEN, SET, LOCKOUT} state_t;
  if (MAX_DIGITS < 4 || MAX_DIGITS > 8 || MAX_FAIL < 1 || MAX_FAIL > 3 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("passcode_fsm: illegal parameters");
  end
  state_t         state, state_n;
  logic [W-1:0]   dbuf, dbuf_n, code, code_n;
  logic [3:0]     len, len_n, cnt_n;
  logic [1:0]     fail_n;
  logic           ovf, ovf_n, clr, digit_ok, match;
  logic           door_n, err_n, saved_n, lock_n, set_n;
  logic [OW-1:0]  open_tmr, open_tmr_n;
  logic [LW-1:0]  lock_tmr, lock_tmr_n;
`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]  tmo, tmo_n;
  logic           tmo_exp;
  assign tmo_exp = (state == IDLE || state == SET) && digit_count != 4'd0 && tmo == '0 && !digit_ok;
`endif
  assign digit_ok = num_valid && num_digit <= 4'd9 && !confirm && !long_confirm && (state == IDLE || state == SET);
  assign match = !ovf && digit_count == len && dbuf == code;
  always_comb begin
    state_n    = state;
    dbuf_n     = dbuf;
    cnt_n      = digit_count;
    ovf_n      = ovf;
    code_n     = code;
    len_n      = len;
    fail_n     = fail_count;
    open_tmr_n = open_tmr;
    lock_tmr_n = lock_tmr;
    door_n     = door_open;
    lock_n     = locked_out;
    set_n      = set_mode;
    err_n      = 1'b0;
    saved_n    = 1'b0;
    clr        = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
    tmo_n = digit_ok ? TW'(TIMEOUT_CYCLES) : (tmo != '0 ? tmo - TW'(1) : tmo);
`endif
    if (digit_ok) begin
      if (digit_count == 4'(MAX_DIGITS)) ovf_n = 1'b1;
      else begin
        dbuf_n = {dbuf[W-5:0], num_digit};
        cnt_n  = digit_count + 4'd1;
      end
    end
    case (state)
      IDLE:
        if (long_confirm) clr = 1'b1;
        else if (confirm) begin
          clr = 1'b1;
          if (match) begin
            state_n    = OPEN;
            door_n     = 1'b1;
            fail_n     = 2'd0;
            open_tmr_n = OW'(OPEN_CYCLES - 1);
          end else begin
            err_n  = 1'b1;
            fail_n = fail_count + 2'd1;
            if (fail_n >= 2'(MAX_FAIL)) begin
              state_n    = LOCKOUT;
              lock_n     = 1'b1;
              lock_tmr_n = LW'(LOCKOUT_CYCLES - 1);
            end
          end
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (tmo_exp) clr = 1'b1;
`endif
      OPEN:
        if (long_confirm) begin
          state_n = SET;
          door_n  = 1'b0;
          set_n   = 1'b1;
          clr     = 1'b1;
        end else if (open_tmr == '0) begin
          state_n = IDLE;
          door_n  = 1'b0;
        end else open_tmr_n = open_tmr - OW'(1);
      SET:
        if (long_confirm) begin
          state_n = IDLE;
          set_n   = 1'b0;
          clr     = 1'b1;
        end else if (confirm) begin
          clr = 1'b1;
          if (!ovf && digit_count >= 4'(MIN_DIGITS)) begin
            code_n  = dbuf;
            len_n   = digit_count;
            saved_n = 1'b1;
            state_n = IDLE;
            set_n   = 1'b0;
          end else err_n = 1'b1;
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (tmo_exp) begin
          clr     = 1'b1;
          state_n = IDLE;
          set_n   = 1'b0;
        end
`endif
      LOCKOUT:
        if (lock_tmr == '0) begin
          state_n = IDLE;
          lock_n  = 1'b0;
          fail_n  = 2'd0;
        end else lock_tmr_n = lock_tmr - LW'(1);
    endcase
    if (clr) begin
      dbuf_n = '0;
      cnt_n  = 4'd0;
      ovf_n  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      dbuf        <= '0;
      digit_count <= 4'd0;
      ovf         <= 1'b0;
      code        <= W'(DEFAULT_CODE);
      len         <= 4'(DEFAULT_LEN);
      fail_count  <= 2'd0;
      open_tmr    <= '0;
      lock_tmr    <= '0;
      door_open   <= 1'b0;
      err_pulse   <= 1'b0;
      saved_pulse <= 1'b0;
      locked_out  <= 1'b0;
      set_mode    <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      tmo         <= '0;
`endif
    end else begin
      state       <= state_n;
      dbuf        <= dbuf_n;
      digit_count <= cnt_n;
      ovf         <= ovf_n;
      code        <= code_n;
      len         <= len_n;
      fail_count  <= fail_n;
      open_tmr    <= open_tmr_n;
      lock_tmr    <= lock_tmr_n;
      door_open   <= door_n;
      err_pulse   <= err_n;
      saved_pulse <= saved_n;
      locked_out  <= lock_n;
      set_mode    <= set_n;
`ifdef ENTRY_TIMEOUT_EN
      tmo         <= tmo_n;
`endif
    end
endmodule

// File: tb/tb_passcode_fsm.sv
// tb_passcode_fsm: scoreboard bench for passcode_fsm (event queue checked by a negedge monitor)
module tb_passcode_fsm;
  logic clk = 1'b0, rst_n = 1'b1, num_valid = 1'b0, confirm = 1'b0, long_confirm = 1'b0;
  logic [3:0] num_digit = 4'd0;
  logic door_open, err_pulse, saved_pulse, locked_out, set_mode;
  logic [3:0] digit_count;
  logic [1:0] fail_count;
  int total = 0, bad = 0;
  typedef struct packed { logic [3:0] mask; logic [1:0] fc; logic sm; } ev_t;
  ev_t sbq[$];
  logic prev_door = 1'b0, prev_lock = 1'b0;
  localparam logic [3:0] EV_OPEN = 4'b1000, EV_ERR = 4'b0100, EV_SAVED = 4'b0010, EV_LOCK = 4'b0001;
  passcode_fsm dut (
    .clk(clk), .rst_n(rst_n), .num_valid(num_valid), .num_digit(num_digit),
    .confirm(confirm), .long_confirm(long_confirm), .door_open(door_open),
    .err_pulse(err_pulse), .saved_pulse(saved_pulse), .locked_out(locked_out),
    .set_mode(set_mode), .digit_count(digit_count), .fail_count(fail_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [3:0] m;
    ev_t e;
    m = {door_open & ~prev_door, err_pulse, saved_pulse, locked_out & ~prev_lock};
    prev_door = door_open;
    prev_lock = locked_out;
    if (rst_n && m != 4'd0) begin
      if (sbq.size() == 0) chk("unexpected_event", 32'(m), 0);
      else begin
        e = sbq.pop_front();
        chk("event_mask", 32'(m), 32'(e.mask));
        chk("event_fail_count", 32'(fail_count), 32'(e.fc));
        chk("event_set_mode", 32'(set_mode), 32'(e.sm));
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic key(input logic [3:0] d);
    num_digit = d;
    num_valid = 1'b1;
    tick();
    num_valid = 1'b0;
  endtask
  task automatic enter(input logic [31:0] c, input int n);
    for (int i = n - 1; i >= 0; i--) key(c[4*i +: 4]);
  endtask
  task automatic star(input logic lng, input logic [3:0] mask, input logic [1:0] fc, input logic sm);
    if (mask != 4'd0) sbq.push_back('{mask, fc, sm});
    if (lng) long_confirm = 1'b1;
    else confirm = 1'b1;
    tick();
    confirm = 1'b0;
    long_confirm = 1'b0;
  endtask
  task automatic wait_low(output int n);
    n = 0;
    while ((door_open || locked_out) && n < 400) begin
      tick();
      n++;
    end
  endtask
  initial begin
    int n;
    #2 rst_n = 1'b0;
    tick(3);
    chk("rst_door_open", 32'(door_open), 0);
    chk("rst_err_pulse", 32'(err_pulse), 0);
    chk("rst_saved_pulse", 32'(saved_pulse), 0);
    chk("rst_locked_out", 32'(locked_out), 0);
    chk("rst_set_mode", 32'(set_mode), 0);
    chk("rst_digit_count", 32'(digit_count), 0);
    chk("rst_fail_count", 32'(fail_count), 0);
    rst_n = 1'b1;
    tick();
    enter(32'h1234, 4);
    chk("count_after_4", 32'(digit_count), 4);
    star(1'b0, EV_OPEN, 2'd0, 1'b0);
    chk("count_after_open", 32'(digit_count), 0);
    wait_low(n);
    chk("open_window_len", n, 50);
    key(4'd10);
    chk("digit_10_ignored", 32'(digit_count), 0);
    key(4'd5);
    key(4'd12);
    chk("digit_12_ignored", 32'(digit_count), 1);
    star(1'b1, 4'd0, 2'd0, 1'b0);
    chk("idle_cancel", 32'(digit_count), 0);
    enter(32'h1235, 4);
    star(1'b0, EV_ERR, 2'd1, 1'b0);
    enter(32'h1235, 4);
    star(1'b0, EV_ERR, 2'd2, 1'b0);
    enter(32'h1235, 4);
    star(1'b0, EV_ERR | EV_LOCK, 2'd3, 1'b0);
    n = 0;
    while (locked_out && n < 400) begin
      if (n < 3) key(4'd1);
      else if (n == 3) star(1'b0, 4'd0, 2'd0, 1'b0);
      else tick();
      n++;
    end
    chk("lockout_len", n, 300);
    chk("lockout_digits_ignored", 32'(digit_count), 0);
    chk("fail_cleared_after_lockout", 32'(fail_count), 0);
    enter(32'h1234, 4);
    star(1'b0, EV_OPEN, 2'd0, 1'b0);
    wait_low(n);
    enter(32'h12345678, 8);
    key(4'd9);
    chk("overflow_saturates", 32'(digit_count), 8);
    star(1'b0, EV_ERR, 2'd1, 1'b0);
    chk("overflow_cleared", 32'(digit_count), 0);
    enter(32'h1234, 4);
    star(1'b0, EV_OPEN, 2'd0, 1'b0);
    star(1'b0, 4'd0, 2'd0, 1'b0);
    chk("confirm_in_open_ignored", 32'(door_open), 1);
    star(1'b1, 4'd0, 2'd0, 1'b0);
    chk("set_mode_entered", 32'(set_mode), 1);
    chk("door_closed_in_set", 32'(door_open), 0);
    enter(32'h56789, 5);
    star(1'b0, EV_SAVED, 2'd0, 1'b0);
    chk("set_mode_left", 32'(set_mode), 0);
    enter(32'h1234, 4);
    star(1'b0, EV_ERR, 2'd1, 1'b0);
    enter(32'h56789, 5);
    star(1'b0, EV_OPEN, 2'd0, 1'b0);
    wait_low(n);
    chk("new_code_window_len", n, 50);
    enter(32'h56789, 5);
    star(1'b0, EV_OPEN, 2'd0, 1'b0);
    star(1'b1, 4'd0, 2'd0, 1'b0);
    enter(32'h123, 3);
    star(1'b0, EV_ERR, 2'd0, 1'b1);
    chk("set_short_stays_set", 32'(set_mode), 1);
    chk("set_short_cleared", 32'(digit_count), 0);
    star(1'b1, 4'd0, 2'd0, 1'b0);
    chk("set_abort", 32'(set_mode), 0);
    enter(32'h56789, 5);
    star(1'b0, EV_OPEN, 2'd0, 1'b0);
    wait_low(n);
    enter(32'h123, 3);
    sbq.push_back('{EV_ERR, 2'd1, 1'b0});
    num_digit = 4'd4;
    num_valid = 1'b1;
    confirm = 1'b1;
    tick();
    num_valid = 1'b0;
    confirm = 1'b0;
    chk("coincident_cleared", 32'(digit_count), 0);
    enter(32'h56789, 5);
    star(1'b0, EV_OPEN, 2'd0, 1'b0);
    wait_low(n);
    enter(32'h56789, 5);
    confirm = 1'b1;
    long_confirm = 1'b1;
    tick();
    confirm = 1'b0;
    long_confirm = 1'b0;
    chk("long_wins_cleared", 32'(digit_count), 0);
    chk("long_wins_closed", 32'(door_open), 0);
    enter(32'h12, 2);
    tick(210);
`ifdef ENTRY_TIMEOUT_EN
    chk("entry_timeout", 32'(digit_count), 0);
`else
    chk("entry_persists", 32'(digit_count), 2);
`endif
    star(1'b1, 4'd0, 2'd0, 1'b0);
    star(1'b0, EV_ERR, 2'd1, 1'b0);
    enter(32'h56789, 5);
    star(1'b0, EV_OPEN, 2'd0, 1'b0);
    tick(5);
    rst_n = 1'b0;
    #2;
    chk("midreset_door", 32'(door_open), 0);
    chk("midreset_fail", 32'(fail_count), 0);
    rst_n = 1'b1;
    tick();
    enter(32'h56789, 5);
    star(1'b0, EV_ERR, 2'd1, 1'b0);
    enter(32'h1234, 4);
    star(1'b0, EV_OPEN, 2'd0, 1'b0);
    wait_low(n);
    chk("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
